// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial bit-sequence detector.
// Matches a pattern of 1..MAX_LEN bits, with overlapping or non-overlapping
// detection, and skips cycles where x_valid is low.
// Optional feature: define SEQ_DET_CNT_EN to build a saturating match counter;
// without it match_count is tied to zero and cnt_clr is ignored.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    // Active configuration
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               err_q, err_d;

    // Datapath state: hist_q[0] is the newest bit; fill_q counts usable bits
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;

    // Candidate values for a valid-bit edge
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Compare window: only the low len bits of pattern/history take part
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Post-shift history and fill, and the match condition on them
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], x};
        fill_inc   = (fill_q >= LEN_MAX) ? LEN_MAX : fill_q + 1'b1;
        match      = (fill_inc >= len_q) &&
                     (((hist_shift ^ pat_q) & len_mask) == '0) &&
                     !err_q;
    end

    // Next-state selection: config load beats data; a stall holds everything but z
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        err_d  = err_q;
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = cfg_len;
            ovl_d  = cfg_overlap;
            err_d  = (cfg_len == '0) || (cfg_len > LEN_MAX);
            hist_d = '0;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = hist_shift;
            fill_d = (match && !ovl_q) ? '0 : fill_inc;
            z_d    = match;
        end
    end

    // State registers with asynchronous reset to the documented defaults
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            pat_q  <= '0;
            len_q  <= LEN_MAX;
            ovl_q  <= 1'b1;
            err_q  <= 1'b0;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            err_q  <= err_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z       = z_q;
    assign cfg_err = err_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating match counter; clear takes priority over a same-edge increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (z_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlap/non-overlap, stalls,
// mid-stream reload, illegal length, async reset, len=1, saturating counter.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               x, x_valid, cfg_load, cfg_overlap, cnt_clr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               z, cfg_err;
    logic [CNT_W-1:0]   match_count;

    int errors = 0;
    int checks = 0;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .z           (z),
        .cfg_err     (cfg_err),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given data inputs; outputs sampled 1 time unit later
    task automatic step(input logic xb, input logic vb);
        x       = xb;
        x_valid = vb;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        step(1'b1, 1'b1);   // data on the load edge must be discarded
        cfg_load    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [6:0] stream;
    logic [6:0] exp_ovl;
    logic [6:0] exp_novl;

    initial begin
        reset_n = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b1;
        #12;
        check("reset_z", 32'(z), 0);
        check("reset_err", 32'(cfg_err), 0);
        check("reset_cnt", 32'(match_count), 0);
        reset_n = 1'b1;

        // Default config after reset: pattern 0, len 8, overlap on
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("default_zero_bit%0d", i), 32'(z), (i >= 8) ? 1 : 0);
        end

        // Stream 1,0,1,1,0,1,1 (MSB first); expected z per bit
        stream   = 7'b1011011;
        exp_ovl  = 7'b0001001;
        exp_novl = 7'b0001000;

        load(8'b0000_1011, 4'd4, 1'b1);
        check("load_no_z", 32'(z), 0);
        for (int i = 6; i >= 0; i--) begin
            step(stream[i], 1'b1);
            check($sformatf("ovl_bit%0d", 7 - i), 32'(z), 32'(exp_ovl[i]));
        end

        load(8'b0000_1011, 4'd4, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            step(stream[i], 1'b1);
            check($sformatf("novl_bit%0d", 7 - i), 32'(z), 32'(exp_novl[i]));
        end

        // Stalls between every bit
        load(8'b0000_1011, 4'd4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            step(stream[i + 3], 1'b1);
            check($sformatf("stall_valid%0d", 4 - i), 32'(z), (i == 0) ? 1 : 0);
            step(1'b1, 1'b0);
            check($sformatf("stall_gap%0d", 4 - i), 32'(z), 0);
        end

        // Reload mid-stream clears history
        load(8'b0000_1011, 4'd4, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        load(8'b0000_1011, 4'd4, 1'b1);
        check("reload_edge_z", 32'(z), 0);
        step(1'b1, 1'b1);
        check("reload_after_z", 32'(z), 0);

        // Unused pattern bits above len are ignored
        load(8'b1111_0101, 4'd3, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        check("upper_bits_pre", 32'(z), 0);
        step(1'b1, 1'b1);
        check("upper_bits_match", 32'(z), 1);

        // len=1, non-overlapping
        load(8'b0000_0001, 4'd1, 1'b0);
        step(1'b1, 1'b1); check("len1_a", 32'(z), 1);
        step(1'b1, 1'b1); check("len1_b", 32'(z), 1);
        step(1'b0, 1'b1); check("len1_c", 32'(z), 0);
        step(1'b1, 1'b1); check("len1_d", 32'(z), 1);

        // Illegal lengths
        load(8'b0000_1011, 4'd9, 1'b1);
        check("len9_err", 32'(cfg_err), 1);
        load(8'b0000_1011, 4'd4, 1'b1);
        check("legal_clears_err", 32'(cfg_err), 0);
        load(8'b0000_1011, 4'd0, 1'b1);
        check("len0_err", 32'(cfg_err), 1);
        begin
            int zc = 0;
            for (int r = 0; r < 2; r++)
                for (int i = 3; i >= 0; i--) begin
                    step(stream[i + 3], 1'b1);
                    zc += int'(z);
                end
            check("err_no_z", 32'(zc), 0);
        end
        check("err_sticky", 32'(cfg_err), 1);

        // Async reset clears cfg_err immediately
        reset_n = 1'b0;
        #1;
        check("async_err_clr", 32'(cfg_err), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Reset after 101 of 1011, then 1 -> no z
        load(8'b0000_1011, 4'd4, 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midreset_z", 32'(z), 0);
        check("midreset_err", 32'(cfg_err), 0);
        check("midreset_cnt", 32'(match_count), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step(1'b1, 1'b1);
        check("after_reset_z", 32'(z), 0);

        // Match counter
        do_reset();
        load(8'b0000_0001, 4'd1, 1'b1);
`ifdef SEQ_DET_CNT_EN
        check("cnt_after_load", 32'(match_count), 0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("cnt_sat%0d", i), 32'(match_count), (i < 3) ? i : 3);
        end
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("cnt_clr_wins_z", 32'(z), 1);
        check("cnt_clr_wins", 32'(match_count), 0);
        step(1'b1, 1'b1);
        check("cnt_resume", 32'(match_count), 1);
        load(8'b0000_0001, 4'd1, 1'b1);
        check("cnt_kept_on_load", 32'(match_count), 1);
`else
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            check($sformatf("cnt_off_z%0d", i), 32'(z), 1);
        end
        check("cnt_off", 32'(match_count), 0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        check("cnt_off_clr", 32'(match_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
